// File: rtl/fp_acc_seq_if.sv
// fp_acc_seq_if: sample-in and result-out valid/ready streams of the FP32
// accumulator. The slave modport is the accumulator's view; the master
// modport is the producer/consumer environment's view.
interface fp_acc_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp_acc_seq.sv
// fp_acc_seq: sequential FP32 accumulator wrapped around an external
// combinational adder. It sums a programmed number of |sample| values and
// hands the total out on a valid/ready stream.
// Optional feature: define FP_ACC_SAT_EN to saturate to +inf on exponent
// overflow and raise the sticky ovf flag; otherwise the raw adder sum is kept
// and ovf stays 0.
module fp_acc_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    fp_acc_seq_if.slave      bus,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_s,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      sample_abs;
    logic             unused_sign;

    // The adder only understands positive operands, so the sign bit is
    // dropped here and never reaches the datapath.
    assign sample_abs  = {1'b0, bus.in_data[30:0]};
    assign unused_sign = bus.in_data[31];

    // State register: all flops share one synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 32'h0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update; the first sample of a run bypasses the
    // adder so a zero accumulator is never presented as an operand.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    first_d = 1'b1;
                    if (len == '0) begin
                        acc_d   = 32'h0;
                        state_d = DONE;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (bus.in_valid) begin
                    if (first_q) begin
                        acc_d   = sample_abs;
                        first_d = 1'b0;
                    end else begin
`ifdef FP_ACC_SAT_EN
                        if (ovf_q) begin
                            acc_d = POS_INF;
                        end else if (add_s[30:23] == 8'hFF) begin
                            acc_d = POS_INF;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = add_s;
                        end
`else
                        acc_d = add_s;
`endif
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    first_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifndef FP_ACC_SAT_EN
        ovf_d = 1'b0;
`endif
    end

    // Outputs decode from the state alone; the adder operands are always live.
    always_comb begin
        bus.in_ready  = (state_q == ACC);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = acc_q;
        busy          = (state_q == ACC) || (state_q == DONE);
        ovf           = ovf_q;
        add_a         = acc_q;
        add_b         = sample_abs;
    end

endmodule

// File: tb/tb_fp_acc_seq.sv
// tb_fp_acc_seq: directed, table-driven bench for fp_acc_seq with a
// behavioural model of the external positive-normalised FP32 adder.
module tb_fp_acc_seq;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_s;
    logic             busy;
    logic             ovf;

    int testsRun;
    int testsFailed;

    fp_acc_seq_if bus();

    fp_acc_seq #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .bus   (bus),
        .add_a (add_a),
        .add_b (add_b),
        .add_s (add_s),
        .busy  (busy),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating adder for positive normalised operands; the exponent simply
    // wraps into 8'hFF on overflow, like the raw hardware adder.
    function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, et, e;
        logic [24:0] ma, mb, mt, sum;
        logic [22:0] m;
        ea = a[30:23];
        eb = b[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        if (ea < eb) begin
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        mb  = mb >> (ea - eb);
        sum = ma + mb;
        if (sum[24]) begin
            e = ea + 8'd1;
            m = sum[23:1];
        end else begin
            e = ea;
            m = sum[22:0];
        end
        return {1'b0, e, m};
    endfunction

    assign add_s = fpAdd(add_a, add_b);

    typedef struct {
        int              n;
        logic [3:0][31:0] s;
        logic [31:0]     expData;
        logic            expOvf;
    } vec_t;

`ifdef FP_ACC_SAT_EN
    localparam logic [31:0] OVF_DATA  = 32'h7F80_0000;
    localparam logic        OVF_FLAG  = 1'b1;
`else
    localparam logic [31:0] OVF_DATA  = 32'h7FFF_FFFF;
    localparam logic        OVF_FLAG  = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Full run with an always-ready consumer: start, one sample per cycle,
    // then the result is checked and consumed.
    task automatic applyStimulus(input string tag, input vec_t v);
        start = 1'b1;
        len   = CNT_W'(v.n);
        tick();
        start = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
            checkOutput({tag, " busy acc"}, 32'(busy), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = v.s[i];
            tick();
        end
        bus.in_valid = 1'b0;
        checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, " busy done"}, 32'(busy), 32'd1);
        checkOutput({tag, " in_ready done"}, 32'(bus.in_ready), 32'd0);
        checkOutput({tag, " out_data"}, bus.out_data, v.expData);
        checkOutput({tag, " ovf"}, 32'(ovf), 32'(v.expOvf));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        len           = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b0;

        vecs[0] = '{n: 2, s: {32'h0, 32'h0, 32'h4000_0000, 32'h3F80_0000}, expData: 32'h4040_0000, expOvf: 1'b0};
        vecs[1] = '{n: 1, s: {32'h0, 32'h0, 32'h0, 32'hBF80_0000}, expData: 32'h3F80_0000, expOvf: 1'b0};
        vecs[2] = '{n: 2, s: {32'h0, 32'h0, 32'h7F7F_FFFF, 32'h7F7F_FFFF}, expData: OVF_DATA, expOvf: OVF_FLAG};
        vecs[3] = '{n: 3, s: {32'h0, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, expData: 32'h4040_0000, expOvf: 1'b0};
        vecs[4] = '{n: 2, s: {32'h0, 32'h0, 32'hBF80_0000, 32'hC000_0000}, expData: 32'h4040_0000, expOvf: 1'b0};
        vecs[5] = '{n: 3, s: {32'h0, 32'h3F80_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF}, expData: OVF_DATA, expOvf: OVF_FLAG};

        tick();
        tick();
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset out_data", bus.out_data, 32'h0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle without start", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressured run: gaps on the input, consumer stalls for 5 cycles,
        // stray in_valid and start during DONE must be ignored.
        start = 1'b1;
        len   = CNT_W'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b0;
            tick();
            checkOutput($sformatf("bp gap%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h3F80_0000;
            tick();
        end
        bus.in_data = 32'h4000_0000;
        start       = 1'b1;
        len         = CNT_W'(2);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp stall%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("bp stall%0d out_data", i), bus.out_data, 32'h4080_0000);
            checkOutput($sformatf("bp stall%0d in_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        start         = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp idle out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("bp idle busy", 32'(busy), 32'd0);

        // Empty run goes straight to DONE with a zero result.
        start = 1'b1;
        len   = '0;
        tick();
        start = 1'b0;
        checkOutput("empty out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("empty out_data", bus.out_data, 32'h0);
        checkOutput("empty in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("empty idle busy", 32'(busy), 32'd0);

        // Reset in the middle of a run, then a fresh single-sample run.
        start = 1'b1;
        len   = CNT_W'(4);
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3F80_0000;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        checkOutput("midrst in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("midrst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        checkOutput("midrst out_data", bus.out_data, 32'h0);
        checkOutput("midrst ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        v = '{n: 1, s: {32'h0, 32'h0, 32'h0, 32'h3FC0_0000}, expData: 32'h3FC0_0000, expOvf: 1'b0};
        applyStimulus("post-reset", v);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fp_acc_seq.md
Name: fp_acc_seq

Overview:
Sequential accumulator controller that wraps the team's combinational single-precision adder.
- Drives the adder's two operand inputs and consumes its sum.
- Accepts a stream of FP32 samples over a valid/ready handshake and sums a programmed number of them.
- Presents the total on an output valid/ready handshake.
- The adder handles only positive, normalised operands with no zero support. This block strips signs and never presents an empty (zero) accumulator to it.

Parameters:
CNT_W, 8, width of the sample-count field len (maximum 2^CNT_W-1 samples per run)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  one-cycle run request; honoured only in IDLE
len  input  CNT_W  number of samples in the run; sampled with start
in_valid  input  1  sample valid
in_ready  output  1  sample accepted when in_valid&in_ready
in_data  input  32  FP32 sample; bit 31 is ignored
add_a  output  32  to adder operand A = accumulator register
add_b  output  32  to adder operand B = {1'b0, in_data[30:0]}
add_s  input  32  sum returned combinationally by the adder
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid&out_ready
out_data  output  32  accumulated FP32 result
busy  output  1  high in ACC and DONE
ovf  output  1  exponent-overflow sticky flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-run:
  - state=IDLE; acc=32'h0; cnt=0; first=1; ovf=0.
  - in_ready=0, out_valid=0, busy=0, out_data=32'h0.
- States: IDLE, ACC, DONE.
- IDLE:
  - start=1 and len!=0 -> ACC; cnt<=len, first<=1.
  - start=1 and len==0 -> DONE; acc<=32'h0.
  - start=0 -> stay.
- ACC:
  - in_ready=1 (combinational from state only).
  - On each accepted sample:
    - If first=1: acc<={1'b0,in_data[30:0]} and first<=0. The adder result is ignored.
    - Else: acc<=add_s.
    - cnt<=cnt-1.
    - If cnt==1 -> DONE next cycle.
  - No accept -> hold all state.
  - Throughput: one sample per cycle. Latency from last accept to out_valid is 1 cycle.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0.
  - On out_ready=1 -> IDLE and first<=1. acc holds its value until the next run's first sample.
- start is ignored outside IDLE. An in_valid outside ACC is not accepted.
- add_a and add_b are driven combinationally at all times. Values presented outside ACC are don't-care.
- Signs: every sample is treated as |x|. out_data[31] is always 0.
- Zero/denormal samples: no special handling. They are passed to the adder as-is. Behaviour is defined only by the adder's raw result.

Optional Feature:
Macro FP_ACC_SAT_EN.
- Defined:
  - If an accepted add yields add_s[30:23]==8'hFF, then acc<=32'h7F800000 (+inf) and ovf<=1.
  - Once ovf=1, acc holds 32'h7F800000 for the rest of the run. Later samples are still accepted and counted.
  - ovf clears on reset or on the next accepted start.
- Undefined: acc<=add_s unconditionally, and ovf is tied to 0.

Test Plan:
- Two-sample sum:
  - Stimulus: reset, start with len=2, samples 32'h3F800000 (1.0) then 32'h40000000 (2.0), out_ready=1.
  - Response: out_valid one cycle after the 2nd accept, out_data=32'h40400000 (3.0), busy=1 for 3 cycles.
- Backpressured run:
  - Stimulus: len=4, four samples of 32'h3F800000 with in_valid gaps, then out_ready held low 5 cycles.
  - Response: out_data=32'h40800000 (4.0) held stable with out_valid=1 throughout, then IDLE after out_ready=1.
- Sign strip and single sample:
  - Stimulus: len=1, sample 32'hBF800000.
  - Response: out_data=32'h3F800000; the adder result is ignored on that cycle.
- Empty run:
  - Stimulus: start with len=0.
  - Response: out_valid next cycle, out_data=32'h0, in_ready stays 0.
- Overflow:
  - Stimulus: len=2, two samples of 32'h7F7FFFFF.
  - Response: with FP_ACC_SAT_EN, out_data=32'h7F800000 and ovf=1. Without it, out_data=32'h7FFFFFFF and ovf=0.
- Reset mid-run:
  - Stimulus: rst_n low for 1 cycle after 2 of 4 samples in ACC, then start with len=1 and sample 32'h3FC00000.
  - Response: all outputs at reset values, in_ready=0, next run gives out_data=32'h3FC00000.
